// File: rtl/lsu_bram_ctrl.sv
// Load/store sequencer between the MEM stage and a single-port synchronous BRAM.
// Misaligned half/word accesses take two BRAM beats; load data is aligned and extended on return.
module lsu_bram_ctrl #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic [2:0]        req_ext,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              stall,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = DATA_W / 8;
  localparam int unsigned OFF_W  = 2;

  localparam logic [2:0] EXT_LBU = 3'b000;
  localparam logic [2:0] EXT_LHU = 3'b001;
  localparam logic [2:0] EXT_LB  = 3'b010;
  localparam logic [2:0] EXT_LH  = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RD_LAST  = 2'd1,
    S_RD_SPLIT = 2'd2,
    S_WR_SPLIT = 2'd3
  } state_t;

  // Lane mask of an access starting at lane 0; size 11 behaves as a word.
  function automatic logic [LANES-1:0] size_lanes(input logic [1:0] size);
    case (size)
      2'b01:   size_lanes = LANES'(4'b0001);
      2'b10:   size_lanes = LANES'(4'b0011);
      default: size_lanes = LANES'(4'b1111);
    endcase
  endfunction

  function automatic logic [LANES-1:0] lanes_first(input logic [1:0] size,
                                                   input logic [OFF_W-1:0] off);
    logic [2*LANES-1:0] span;
    span        = {{LANES{1'b0}}, size_lanes(size)} << off;
    lanes_first = span[LANES-1:0];
  endfunction

  // Lanes that spill past byte 3 land in the next word.
  function automatic logic [LANES-1:0] lanes_second(input logic [1:0] size,
                                                    input logic [OFF_W-1:0] off);
    logic [2*LANES-1:0] span;
    span         = {{LANES{1'b0}}, size_lanes(size)} << off;
    lanes_second = span[2*LANES-1:LANES];
  endfunction

  function automatic logic [DATA_W-1:0] rotl_lanes(input logic [DATA_W-1:0] data,
                                                   input logic [OFF_W-1:0] off);
    logic [2*DATA_W-1:0] dbl;
    dbl        = {data, data} << {off, 3'b000};
    rotl_lanes = dbl[2*DATA_W-1:DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] hi,
                                                  input logic [DATA_W-1:0] lo,
                                                  input logic [OFF_W-1:0] off);
    logic [2*DATA_W-1:0] dbl;
    dbl       = {hi, lo} >> {off, 3'b000};
    shift_out = dbl[DATA_W-1:0];
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [OFF_W-1:0]    r_off;
  logic [1:0]          r_size;
  logic [2:0]          r_ext;
  logic [DATA_W-1:0]   r_wdata;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_split;
  logic [DATA_W-1:0]   r_lo;

  logic [OFF_W-1:0]    w_off;
  logic [ADDR_W-1:0]   w_word;
  logic [LANES-1:0]    w_lanes_lo;
  logic                w_split;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_addr_next;
  logic [DATA_W-1:0]   w_lo;
  logic [DATA_W-1:0]   w_hi;
  logic [DATA_W-1:0]   w_asm;
  logic [DATA_W-1:0]   w_fmt;
  logic                w_unused_addr;

  assign w_off         = req_addr[OFF_W-1:0];
  assign w_word        = req_addr[ADDR_W+1:OFF_W];
  assign w_lanes_lo    = lanes_first(req_size, w_off);
  assign w_split       = |lanes_second(req_size, w_off);
  assign w_addr_next   = r_addr + ADDR_W'(1);
  assign w_unused_addr = ^req_addr[31:ADDR_W+2];
  assign stall         = req_valid & ~req_ready;

  // Load assembly: a split load keeps its first word in r_lo, the second arrives on mem_rdata.
  assign w_lo  = r_split ? r_lo : mem_rdata;
  assign w_hi  = r_split ? mem_rdata : '0;
  assign w_asm = shift_out(w_hi, w_lo, r_off);

  always_comb begin
    case (r_ext)
      EXT_LBU: w_fmt = {{(DATA_W-8){1'b0}}, w_asm[7:0]};
      EXT_LHU: w_fmt = {{(DATA_W-16){1'b0}}, w_asm[15:0]};
      EXT_LB:  w_fmt = {{(DATA_W-8){w_asm[7]}}, w_asm[7:0]};
      EXT_LH:  w_fmt = {{(DATA_W-16){w_asm[15]}}, w_asm[15:0]};
      default: w_fmt = w_asm;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and BRAM/response drive; a first beat may overlap the RD_LAST response.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    w_accept    = 1'b0;
    rsp_valid   = 1'b0;
    rsp_rdata   = '0;
    mem_en      = 1'b0;
    mem_we      = '0;
    mem_addr    = '0;
    mem_wdata   = '0;

    case (r_state)
      S_IDLE: begin
        req_ready = rst_n;
      end
      S_RD_LAST: begin
        req_ready   = rst_n;
        rsp_valid   = 1'b1;
        rsp_rdata   = w_fmt;
        w_state_nxt = S_IDLE;
      end
      S_RD_SPLIT: begin
        mem_en      = 1'b1;
        mem_addr    = w_addr_next;
        w_state_nxt = S_RD_LAST;
      end
      S_WR_SPLIT: begin
        mem_en      = 1'b1;
        mem_we      = lanes_second(r_size, r_off);
        mem_addr    = w_addr_next;
        mem_wdata   = rotl_lanes(r_wdata, r_off);
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_accept = req_valid & req_ready;
    if (w_accept) begin
      mem_en   = 1'b1;
      mem_addr = w_word;
      if (req_we) begin
        mem_we      = w_lanes_lo;
        mem_wdata   = rotl_lanes(req_wdata, w_off);
        w_state_nxt = w_split ? S_WR_SPLIT : S_IDLE;
      end else begin
        w_state_nxt = w_split ? S_RD_SPLIT : S_RD_LAST;
      end
    end
  end

  // Request fields held for the second beat and for formatting the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_off   <= '0;
      r_size  <= '0;
      r_ext   <= '0;
      r_wdata <= '0;
      r_addr  <= '0;
      r_split <= 1'b0;
      r_lo    <= '0;
    end else begin
      if (w_accept) begin
        r_off   <= w_off;
        r_size  <= req_size;
        r_ext   <= req_ext;
        r_wdata <= req_wdata;
        r_addr  <= w_word;
        r_split <= w_split;
      end
      if (r_state == S_RD_SPLIT) begin
        r_lo <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_lsu_bram_ctrl.sv
// Bench for lsu_bram_ctrl: BRAM model plus a byte-addressed reference memory,
// directed steps followed by random loads/stores.
module tb_lsu_bram_ctrl;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned WORDS  = 1 << ADDR_W;
  localparam int unsigned BYTES  = WORDS * 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [31:0]       req_addr = '0;
  logic [1:0]        req_size = '0;
  logic [2:0]        req_ext = '0;
  logic [31:0]       req_wdata = '0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              stall;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;

  logic [31:0]       bram [0:WORDS-1];
  logic [7:0]        refm [0:BYTES-1];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [31:0]       pl_data = '0;

  int                n_checks = 0;
  int                n_pass = 0;
  logic [31:0]       last_rsp = '0;

  lsu_bram_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_ext   (req_ext),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .stall     (stall),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous BRAM with byte enables; pl_* is a bench-only preload port.
  always @(posedge clk) begin
    logic [31:0] nw;
    if (pl_en) begin
      bram[pl_addr] <= pl_data;
    end else if (mem_en) begin
      nw = bram[mem_addr];
      for (int l = 0; l < 4; l++)
        if (mem_we[l]) nw[8*l +: 8] = mem_wdata[8*l +: 8];
      bram[mem_addr] <= nw;
      mem_rdata      <= bram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b01) ? 1 : (size == 2'b10) ? 2 : 4;
  endfunction

  function automatic logic [3:0] exp_lanes(input int off, input int n, input int beat);
    logic [3:0] m;
    m = '0;
    for (int l = 0; l < 4; l++)
      if (beat == 0) m[l] = (l >= off) && (l < off + n);
      else           m[l] = (l + 4 < off + n);
    return m;
  endfunction

  // Store byte i lands on lane (off+i) mod 4.
  function automatic logic [31:0] exp_lane_data(input logic [31:0] d, input int off);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[8*((off + i) % 4) +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] ext);
    int          w;
    logic [31:0] v;
    logic [13:0] ba;
    w = (ext == 3'd0 || ext == 3'd2) ? 1 : (ext == 3'd1 || ext == 3'd3) ? 2 : 4;
    v = '0;
    for (int i = 0; i < w; i++) begin
      ba           = addr[13:0] + 14'(i);
      v[8*i +: 8]  = refm[ba];
    end
    if (ext == 3'd2 && v[7])  v[31:8]  = '1;
    if (ext == 3'd3 && v[15]) v[31:16] = '1;
    return v;
  endfunction

  task automatic preload(input int w, input logic [31:0] v);
    pl_en   = 1'b1;
    pl_addr = ADDR_W'(w);
    pl_data = v;
    for (int i = 0; i < 4; i++) refm[4*w + i] = v[8*i +: 8];
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // One request from an idle controller, checked beat by beat against the reference.
  task automatic run_op(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic [2:0] ext, input logic [31:0] wdata);
    int                off, n;
    logic              split;
    logic [ADDR_W-1:0] a0, a1;
    logic [31:0]       expd, rot;
    off   = int'(addr[1:0]);
    n     = nbytes(size);
    split = (off + n > 4);
    a0    = addr[ADDR_W+1:2];
    a1    = a0 + ADDR_W'(1);
    rot   = exp_lane_data(wdata, off);
    expd  = ref_load(addr, ext);

    req_valid = 1'b1; req_we = we; req_addr = addr;
    req_size  = size; req_ext = ext; req_wdata = wdata;
    #2;
    chk("beat0_ready", 32'(req_ready), 32'd1);
    chk("beat0_en",    32'(mem_en), 32'd1);
    chk("beat0_addr",  32'(mem_addr), 32'(a0));
    chk("beat0_we",    32'(mem_we), we ? 32'(exp_lanes(off, n, 0)) : 32'd0);
    if (we) chk("beat0_wdata", mem_wdata, rot);
    @(posedge clk); #1;

    if (split) begin
      #1;
      chk("beat1_stall", 32'(stall), 32'd1);
      chk("beat1_ready", 32'(req_ready), 32'd0);
      chk("beat1_en",    32'(mem_en), 32'd1);
      chk("beat1_addr",  32'(mem_addr), 32'(a1));
      chk("beat1_we",    32'(mem_we), we ? 32'(exp_lanes(off, n, 1)) : 32'd0);
      chk("beat1_rsp",   32'(rsp_valid), 32'd0);
      if (we) chk("beat1_wdata", mem_wdata, rot);
      @(posedge clk); #1;
    end

    req_valid = 1'b0;
    #1;
    chk("done_en", 32'(mem_en), 32'd0);
    if (!we) begin
      chk("load_valid", 32'(rsp_valid), 32'd1);
      chk("load_data",  rsp_rdata, expd);
      last_rsp = rsp_rdata;
    end else begin
      chk("store_norsp", 32'(rsp_valid), 32'd0);
      for (int i = 0; i < n; i++) refm[addr[13:0] + 14'(i)] = wdata[8*i +: 8];
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [1:0]  sz;
    logic [2:0]  ex;
    logic [31:0] ad;
    int          sel;

    @(posedge clk); #1;
    for (int w = 0; w < int'(WORDS); w++) preload(w, $urandom);
    preload(4, 32'h8899AABB);
    preload(5, 32'h11223344);
    preload(12'hFFF, 32'hCAFEF00D);
    preload(0, 32'h13572468);

    // Held in reset: quiet outputs.
    chk("rst_en",    32'(mem_en), 32'd0);
    chk("rst_we",    32'(mem_we), 32'd0);
    chk("rst_rsp",   32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_stall", 32'(stall), 32'd0);
    chk("idle_addr",  32'(mem_addr), 32'd0);
    chk("idle_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;

    run_op(1'b0, 32'h10, 2'b00, 3'b100, '0); chk("tp_lw",  last_rsp, 32'h8899AABB);
    run_op(1'b0, 32'h13, 2'b01, 3'b010, '0); chk("tp_lb",  last_rsp, 32'hFFFFFF88);
    run_op(1'b0, 32'h13, 2'b01, 3'b000, '0); chk("tp_lbu", last_rsp, 32'h00000088);
    run_op(1'b0, 32'h12, 2'b10, 3'b011, '0); chk("tp_lh",  last_rsp, 32'hFFFF8899);
    run_op(1'b0, 32'h12, 2'b10, 3'b001, '0); chk("tp_lhu", last_rsp, 32'h00008899);
    run_op(1'b0, 32'h13, 2'b10, 3'b011, '0); chk("tp_lh_split", last_rsp, 32'h00004488);
    run_op(1'b1, 32'h0E, 2'b00, 3'b100, 32'hDEADBEEF);
    run_op(1'b0, 32'h10, 2'b00, 3'b100, '0); chk("tp_after_sw", last_rsp, 32'h8899DEAD);
    run_op(1'b0, 32'h3FFD, 2'b00, 3'b100, '0); chk("tp_wrap", last_rsp, 32'h68CAFEF0);

    // Back-to-back aligned loads: one response per cycle.
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20 + 32'(4 * k);
        req_size  = 2'b00; req_ext = 3'b100;
      end else begin
        req_valid = 1'b0;
      end
      #2;
      if (k < 3) chk("b2b_addr", 32'(mem_addr), 32'(8 + k));
      if (k > 0) begin
        chk("b2b_valid", 32'(rsp_valid), 32'd1);
        chk("b2b_data",  rsp_rdata, ref_load(32'h20 + 32'(4 * (k - 1)), 3'b100));
      end
      @(posedge clk); #1;
    end
    #1;
    chk("b2b_end", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;

    // Reset while a split load waits for its second beat.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h13; req_size = 2'b10; req_ext = 3'b011;
    #2;
    chk("rs_beat0", 32'(mem_addr), 32'd4);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rs_no_beat1", 32'(mem_en), 32'd0);
    chk("rs_rsp0",     32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("rs_rsp1",     32'(rsp_valid), 32'd0);
    chk("rs_rdata",    rsp_rdata, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rs_ready",    32'(req_ready), 32'd1);
    chk("rs_rsp2",     32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    run_op(1'b0, 32'h10, 2'b00, 3'b100, '0); chk("rs_lw", last_rsp, 32'h8899DEAD);

    // Random mix; half the addresses fall in a small window so loads see earlier stores.
    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 6);
      case (sel)
        0:       begin sz = 2'b01; ex = 3'b000; end
        1:       begin sz = 2'b01; ex = 3'b010; end
        2:       begin sz = 2'b10; ex = 3'b001; end
        3:       begin sz = 2'b10; ex = 3'b011; end
        4:       begin sz = 2'b00; ex = 3'b100; end
        5:       begin sz = 2'b11; ex = 3'b100; end
        default: begin sz = 2'b00; ex = 3'($urandom_range(5, 7)); end
      endcase
      ad = $urandom;
      if ($urandom_range(0, 1) == 0) ad[13:0] = 14'($urandom_range(0, 63));
      else if ($urandom_range(0, 3) == 0) ad[13:0] = 14'($urandom_range(16368, 16383));
      run_op($urandom_range(0, 2) == 0, ad, sz, ex, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_bram_ctrl.md
Name: lsu_bram_ctrl

Overview:
- Load/store sequencer between the pipelined core's MEM stage and the single-port synchronous BRAM data memory.
- Accepts one load/store per handshake using the MEM-stage size code (ByteAccess) and extension code (ByteSrc).
- Generates BRAM enables, word address, byte-write-enables and lane-aligned write data; formats load data.
- Splits misaligned halfword/word accesses into two BRAM beats and stalls the pipeline while a split or read is in flight.

Parameters:
- ADDR_W, 12, BRAM word-address width; the BRAM holds 2^ADDR_W 32-bit words.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage presents a memory request.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; bits [ADDR_W+1:0] are used, upper bits are ignored.
- req_size  in  2  01 = byte, 10 = half, 00 = word; 11 is treated as word.
- req_ext  in  3  000 = lbu, 001 = lhu, 010 = lb, 011 = lh, 100 = lw; any other value is treated as lw.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  load result valid (one-cycle pulse per load).
- rsp_rdata  out  32  formatted load result.
- stall  out  1  equals req_valid & ~req_ready.
- mem_en  out  1  BRAM access enable.
- mem_we  out  4  BRAM byte write enables.
- mem_addr  out  ADDR_W  BRAM word address.
- mem_wdata  out  32  BRAM write data.
- mem_rdata  in  32  BRAM read data, valid one cycle after mem_en with mem_we = 0.

Behaviour:
- Decoding:
  - off = req_addr[1:0]; nbytes = 1, 2 or 4 from req_size.
  - split = (off + nbytes > 4).
  - A = req_addr[ADDR_W+1:2]; the second beat uses (A+1) mod 2^ADDR_W, so it wraps to word 0.
- First beat (accept cycle): BRAM outputs are driven combinationally from the request.
  - mem_en = 1, mem_addr = A.
  - mem_wdata = rotate-left(req_wdata, 8*off), for both beats of a split store.
  - mem_we (stores only) = the lanes off .. min(off+nbytes-1, 3).
- Second beat (split only):
  - mem_we = lanes 0 .. (off+nbytes-5).
  - Request fields (we, off, size, ext, wdata, A) are held in registers captured at accept.
- FSM states: IDLE, RD_LAST, RD_SPLIT, WR_SPLIT.
  - IDLE: req_ready = 1.
    - Aligned load → RD_LAST.
    - Split load → RD_SPLIT.
    - Aligned store completes in the accept cycle and stays IDLE; no rsp.
    - Split store → WR_SPLIT.
  - RD_SPLIT: req_ready = 0. Capture the low bytes from mem_rdata, issue the read of A+1, go to RD_LAST.
  - RD_LAST: rsp_valid = 1, rsp_rdata formatted from mem_rdata (plus captured bytes if split).
    - req_ready = 1 in this state; a request accepted here issues its first beat in the same cycle and takes the IDLE transitions.
    - With no request, go to IDLE.
  - WR_SPLIT: req_ready = 0. Issue the second write beat, go to IDLE.
- Load latency: aligned = result 1 cycle after accept; split = result 2 cycles after accept. Back-to-back aligned loads sustain 1 per cycle.
- Formatting:
  - Assembled little-endian bytes from off are zero- or sign-extended per req_ext.
  - Sign bit is bit 7 for lb and bit 15 for lh.
  - lw passes all 32 bits.
- Idle outputs: when no beat is issued, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0. rsp_rdata = 0 whenever rsp_valid = 0.
- Reset (asserted, any state):
  - FSM → IDLE; all held registers cleared.
  - rsp_valid = 0, rsp_rdata = 0, mem_en = 0, mem_we = 0; req_ready = 1 after release.
  - An in-flight second beat is never issued, and a partial split store is left as-is.
- req_valid low in IDLE: no BRAM activity and the state is unchanged.

Test Plan:
- BRAM word4 = 0x8899AABB; lw @0x10 → cycle0 mem_en = 1, mem_addr = 4, mem_we = 0; cycle1 rsp_valid = 1, rsp_rdata = 0x8899AABB.
- lb @0x13 → rsp_rdata = 0xFFFFFF88; lbu @0x13 → 0x00000088; lh @0x12 → 0xFFFF8899; lhu @0x12 → 0x00008899.
- word5 = 0x11223344; lh @0x13 → cycle0 addr 4, cycle1 addr 5 with req_ready = 0, cycle2 rsp_rdata = 0x00004488.
- sw 0xDEADBEEF @0x0E → cycle0 addr 3, mem_we = 1100, mem_wdata = 0xBEEFDEAD; cycle1 addr 4, mem_we = 0011, req_ready = 0; stall = 1 in cycle1 if req_valid.
- ADDR_W = 12; lw @0x3FFD → beats to addr 0xFFF then 0x000; also 3 back-to-back aligned lw → rsp_valid high 3 consecutive cycles.
- rst_n low during RD_SPLIT → no second read, rsp_valid stays 0; after release lw @0x10 completes normally.
